if_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline, directly upstream of the decode stage. It holds the PC and reads the word-addressed instruction memory. It latches IR and PC+4 for decode, takes J/JR/branch redirects and squash requests back from decode, and supports hazard stalls and a SYSCALL-driven halt/resume state machine. It also keeps a fetched-instruction counter for the performance display.

---
 rtl/if_stage_if.sv | 31 +++
 rtl/if_stage.sv | 93 +++++++++
 tb/tb_if_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// Bundle between the fetch stage and its neighbours: decode-side control,
// the instruction-memory port, and the IF/ID register outputs.
interface if_stage_if #(
   parameter int unsigned IMEM_AW = 10
);
   logic                stall;
   logic                branch_taken;
   logic [31:0]         branch_target;
   logic                jmp;
   logic                jr;
   logic [31:0]         jaddr;
   logic                halt_req;
   logic                go;
   logic [IMEM_AW-1:0]  imem_addr;
   logic [31:0]         imem_data;
   logic [31:0]         ir;
   logic [31:0]         pc_plus4;
   logic                valid;
   logic                halted;
   logic [31:0]         fetch_count;

   modport master (
      output stall, branch_taken, branch_target, jmp, jr, jaddr, halt_req, go, imem_data,
      input  imem_addr, ir, pc_plus4, valid, halted, fetch_count
   );

   modport slave (
      input  stall, branch_taken, branch_target, jmp, jr, jaddr, halt_req, go, imem_data,
      output imem_addr, ir, pc_plus4, valid, halted, fetch_count
   );
endinterface

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage with IF/ID register, redirect/squash handling,
// SYSCALL halt/resume control and a fetched-instruction counter.
module if_stage #(
   parameter logic [31:0]  PC_RESET = 32'h0000_0000,
   parameter int unsigned  IMEM_AW  = 10
) (
   input  logic      clk,
   input  logic      rst,
   if_stage_if.slave bus
);
   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_t;

   state_t          state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] ir;
   logic [XLEN-1:0] pc_plus4;
   logic            valid;
   logic            halted;
   logic [XLEN-1:0] fetch_count;

   logic [XLEN-1:0] pc_seq_c;
   logic [XLEN-1:0] jmp_target_c;

   assign pc_seq_c     = pc + XLEN'(4);
   // J-type target uses the region bits of the jump's own PC+4
   assign jmp_target_c = {pc_plus4[31:28], bus.jaddr[25:0], 2'b00};

   assign bus.imem_addr   = pc[IMEM_AW+1:2];
   assign bus.ir          = ir;
   assign bus.pc_plus4    = pc_plus4;
   assign bus.valid       = valid;
   assign bus.halted      = halted;
   assign bus.fetch_count = fetch_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         pc          <= PC_RESET;
         ir          <= '0;
         pc_plus4    <= '0;
         valid       <= 1'b0;
         halted      <= 1'b0;
         fetch_count <= '0;
      end else if (!bus.stall) begin
         case (state)
            RUN: begin
               if (bus.halt_req) begin
                  state  <= HALT;
                  halted <= 1'b1;
                  ir     <= '0;
                  valid  <= 1'b0;
               end else if (bus.branch_taken) begin
                  pc    <= bus.branch_target & ALIGN_MASK;
                  ir    <= '0;
                  valid <= 1'b0;
               end else if (bus.jr) begin
                  pc    <= bus.jaddr & ALIGN_MASK;
                  ir    <= '0;
                  valid <= 1'b0;
               end else if (bus.jmp) begin
                  pc    <= jmp_target_c;
                  ir    <= '0;
                  valid <= 1'b0;
               end else begin
                  pc          <= pc_seq_c;
                  ir          <= bus.imem_data;
                  pc_plus4    <= pc_seq_c;
                  valid       <= 1'b1;
                  fetch_count <= fetch_count + XLEN'(1);
               end
            end
            HALT: begin
               ir    <= '0;
               valid <= 1'b0;
               if (bus.go) begin
                  state  <= RUN;
                  halted <= 1'b0;
               end
            end
            default: begin
               state  <= RUN;
               halted <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed control vectors, a spec-level fetch model
// compared every cycle, and literal expectations at key points.
module tb_if_stage;
   localparam int unsigned IMEM_AW = 10;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   if_stage_if #(.IMEM_AW(IMEM_AW)) bus ();

   if_stage #(.PC_RESET(32'h0000_0000), .IMEM_AW(IMEM_AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // instruction memory content: word n holds 0x20080001 + n
   assign bus.imem_data = 32'h2008_0001 + 32'(bus.imem_addr);

   function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
      logic [IMEM_AW-1:0] w;
      w = byte_addr[IMEM_AW+1:2];
      return 32'h2008_0001 + 32'(w);
   endfunction

   int checks   = 0;
   int failures = 0;
   bit cmp_en   = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // architectural model: program counter, IF/ID contents, halt flag, count
   logic [31:0] m_pc, m_ir, m_pp4, m_cnt;
   logic        m_valid, m_halted;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pc = 32'h0; m_ir = 32'h0; m_pp4 = 32'h0; m_cnt = 32'h0;
         m_valid = 1'b0; m_halted = 1'b0;
      end else if (!bus.stall) begin
         if (m_halted) begin
            m_ir = 32'h0; m_valid = 1'b0;
            if (bus.go) m_halted = 1'b0;
         end else if (bus.halt_req) begin
            m_halted = 1'b1; m_ir = 32'h0; m_valid = 1'b0;
         end else if (bus.branch_taken || bus.jr || bus.jmp) begin
            logic [31:0] tgt;
            if (bus.branch_taken) tgt = bus.branch_target;
            else if (bus.jr)      tgt = bus.jaddr;
            else                  tgt = (m_pp4 & 32'hF000_0000) | ((bus.jaddr & 32'h03FF_FFFF) * 4);
            m_pc = tgt & 32'hFFFF_FFFC;
            m_ir = 32'h0; m_valid = 1'b0;
         end else begin
            m_ir    = mem_word(m_pc);
            m_pp4   = m_pc + 32'd4;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
            m_cnt   = m_cnt + 32'd1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         chk("cyc_ir",        bus.ir,                   m_ir);
         chk("cyc_pc_plus4",  bus.pc_plus4,             m_pp4);
         chk("cyc_valid",     32'(bus.valid),           32'(m_valid));
         chk("cyc_halted",    32'(bus.halted),          32'(m_halted));
         chk("cyc_count",     bus.fetch_count,          m_cnt);
         chk("cyc_imem_addr", 32'(bus.imem_addr),       32'(m_pc[IMEM_AW+1:2]));
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jmp = 1'b0; bus.jr = 1'b0;
      bus.halt_req = 1'b0; bus.go = 1'b0;
   endtask

   initial begin
      clear_ctl();
      bus.branch_target = 32'h0;
      bus.jaddr = 32'h0;
      #2 rst = 1'b1;
      #10;
      chk("rst_ir",    bus.ir, 32'h0);
      chk("rst_valid", 32'(bus.valid), 32'h0);
      chk("rst_count", bus.fetch_count, 32'h0);
      chk("rst_halted", 32'(bus.halted), 32'h0);
      chk("rst_addr",  32'(bus.imem_addr), 32'h0);
      @(negedge clk); rst = 1'b0; cmp_en = 1'b1;

      // sequential fetch
      step(4);
      chk("seq_ir",    bus.ir, 32'h2008_0004);
      chk("seq_pp4",   bus.pc_plus4, 32'd16);
      chk("seq_count", bus.fetch_count, 32'd4);
      chk("seq_addr",  32'(bus.imem_addr), 32'h4);

      // stall freezes everything
      bus.stall = 1'b1; bus.jmp = 1'b1; bus.jaddr = 32'h3FF;
      step(3);
      chk("stall_ir",    bus.ir, 32'h2008_0004);
      chk("stall_count", bus.fetch_count, 32'd4);
      chk("stall_addr",  32'(bus.imem_addr), 32'h4);
      clear_ctl();
      step(1);
      chk("unstall_ir",  bus.ir, 32'h2008_0005);
      chk("unstall_pp4", bus.pc_plus4, 32'h14);

      // jump: target = {pp4[31:28], 0x40, 00} = 0x100
      bus.jmp = 1'b1; bus.jaddr = 32'h40;
      step(1); clear_ctl();
      chk("jmp_bubble_valid", 32'(bus.valid), 32'h0);
      chk("jmp_bubble_ir",    bus.ir, 32'h0);
      chk("jmp_pp4_hold",     bus.pc_plus4, 32'h14);
      chk("jmp_addr",         32'(bus.imem_addr), 32'h40);
      step(1);
      chk("jmp_tgt_ir",  bus.ir, 32'h2008_0041);
      chk("jmp_tgt_pp4", bus.pc_plus4, 32'h104);

      // branch beats jr and jmp
      bus.branch_taken = 1'b1; bus.jr = 1'b1; bus.jmp = 1'b1;
      bus.branch_target = 32'h20; bus.jaddr = 32'h80;
      step(1); clear_ctl();
      chk("prio_addr", 32'(bus.imem_addr), 32'h8);
      step(1);
      chk("prio_ir",  bus.ir, 32'h2008_0009);
      chk("prio_pp4", bus.pc_plus4, 32'h24);

      // jr beats jmp; misaligned target rounds down to 0x30
      bus.jr = 1'b1; bus.jmp = 1'b1; bus.jaddr = 32'h33;
      step(1); clear_ctl();
      chk("jr_addr", 32'(bus.imem_addr), 32'hC);
      step(1);
      chk("jr_ir", bus.ir, 32'h2008_000D);

      // go in RUN is harmless
      bus.go = 1'b1; step(1); clear_ctl();
      chk("go_run_halted", 32'(bus.halted), 32'h0);

      // halt at pc=0x38, redirects ignored while halted
      bus.halt_req = 1'b1; step(1); clear_ctl();
      chk("halt_flag", 32'(bus.halted), 32'h1);
      bus.branch_taken = 1'b1; bus.branch_target = 32'h200; bus.halt_req = 1'b1;
      step(5); clear_ctl();
      chk("halt_addr",  32'(bus.imem_addr), 32'hE);
      chk("halt_valid", 32'(bus.valid), 32'h0);
      bus.stall = 1'b1; bus.go = 1'b1; step(2); clear_ctl();
      chk("halt_stall_go", 32'(bus.halted), 32'h1);
      bus.go = 1'b1; step(1); clear_ctl();
      chk("resume_halted", 32'(bus.halted), 32'h0);
      chk("resume_valid",  32'(bus.valid), 32'h0);
      step(1);
      chk("resume_ir",  bus.ir, 32'h2008_000F);
      chk("resume_pp4", bus.pc_plus4, 32'h3C);

      // pc wrap at the top of the address space
      bus.jr = 1'b1; bus.jaddr = 32'hFFFF_FFFC; step(1); clear_ctl();
      step(1);
      chk("wrap_pp4", bus.pc_plus4, 32'h0);
      step(1);
      chk("wrap_ir", bus.ir, 32'h2008_0001);

      // halt then asynchronous reset mid-cycle
      bus.halt_req = 1'b1; step(1); clear_ctl();
      step(2);
      #3 rst = 1'b1;
      #1;
      chk("arst_count",  bus.fetch_count, 32'h0);
      chk("arst_halted", 32'(bus.halted), 32'h0);
      chk("arst_addr",   32'(bus.imem_addr), 32'h0);
      chk("arst_pp4",    bus.pc_plus4, 32'h0);
      @(negedge clk); rst = 1'b0;
      step(2);
      chk("post_rst_ir", bus.ir, 32'h2008_0002);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
